// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory with streaming loader.
// Holds the loader FSM state type and the default geometry constants.
package imem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefDepth = 256;

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port synchronous RAM: one write port and one registered read port.
// The storage array has no reset; only the read data register is cleared.
//
// Ports:
//   clk_i    - clock
//   reset_i  - asynchronous active-high reset (read register only)
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   re_i     - read enable; rdata_o holds its value when low
//   raddr_i  - read address
//   rdata_o  - registered read data
module imem_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Parametrised instruction memory with a built-in valid/ready streaming loader.
// A program image is written word-by-word from address 0 upward; between loads
// the CPU fetch stage reads it with one-cycle latency. Fetch is blocked while
// a load is in progress.
//
// Optional feature: define INSTR_MEM_LED_EN to add led[7:0] = instr[7:0]
// (zero-extended when DATA_W < 8) for board debug.
//
// Ports:
//   clk          - system clock
//   reset        - asynchronous active-high reset
//   fetch_en     - fetch request (honoured in IDLE only)
//   fetch_addr   - fetch word address
//   instr        - fetched instruction (zero during a load)
//   instr_valid  - instr belongs to the previous cycle's accepted fetch
//   load_start   - begin a new program load (ignored during a load)
//   load_data    - stream word
//   load_valid   - load_data valid
//   load_last    - final word of the image, qualified by load_valid
//   load_ready   - loader accepts a word this cycle
//   load_done    - one-cycle pulse when a load completes
//   loaded_count - words written by the last completed load (0..DEPTH)
//   busy         - load in progress (LOAD or DONE)
module instr_mem_loader
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              load_start,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   loaded_count,
`ifdef INSTR_MEM_LED_EN
    output logic [7:0]        led,
`endif
    output logic              busy
);

    // wptr is one bit wider than an address so it can express DEPTH.
    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LastW  = (ADDR_W + 1)'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   loaded_count_q, loaded_count_d;
    logic              instr_valid_q, instr_valid_d;
    logic              fetch_go;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        state_d        = state_q;
        wptr_d         = wptr_q;
        loaded_count_d = loaded_count_q;
        load_ready     = 1'b0;
        load_done      = 1'b0;
        busy           = 1'b0;
        fetch_go       = 1'b0;
        ram_we         = 1'b0;

        unique case (state_q)
            StIdle: begin
                // load_start wins over a simultaneous fetch.
                if (load_start) begin
                    state_d = StLoad;
                    wptr_d  = '0;
                end else begin
                    fetch_go = fetch_en;
                end
            end
            StLoad: begin
                busy       = 1'b1;
                load_ready = (wptr_q < DepthW);
                if (load_valid && load_ready) begin
                    ram_we = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    // The DEPTH-th word closes the load even without load_last.
                    if (load_last || (wptr_q == LastW)) begin
                        state_d        = StDone;
                        loaded_count_d = wptr_q + 1'b1;
                    end
                end
            end
            StDone: begin
                busy      = 1'b1;
                load_done = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        instr_valid_d = fetch_go;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            wptr_q         <= '0;
            loaded_count_q <= '0;
            instr_valid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wptr_q         <= wptr_d;
            loaded_count_q <= loaded_count_d;
            instr_valid_q  <= instr_valid_d;
        end
    end

    imem_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i  (clk),
        .reset_i(reset),
        .we_i   (ram_we),
        .waddr_i(wptr_q[ADDR_W-1:0]),
        .wdata_i(load_data),
        .re_i   (fetch_go),
        .raddr_i(fetch_addr),
        .rdata_o(ram_rdata)
    );

    // The read register keeps its last fetch; it is masked to zero while busy.
    assign instr        = (state_q == StIdle) ? ram_rdata : '0;
    assign instr_valid  = instr_valid_q;
    assign loaded_count = loaded_count_q;

`ifdef INSTR_MEM_LED_EN
    if (DATA_W >= 8) begin : g_led_wide
        assign led = instr[7:0];
    end else begin : g_led_narrow
        assign led = {{(8 - DATA_W){1'b0}}, instr};
    end
`endif

endmodule
